// File: rtl/mult_seq_if.sv
// Control bus between the shift-add multiplier sequencer and its datapath/environment.
interface mult_seq_if;
  logic       Run;
  logic       ClearA_LoadB;
  logic       M;
  logic       ClearA;
  logic       LoadB;
  logic       LoadA;
  logic       Fn;
  logic       Shift;
  logic       Busy;
  logic       Done;
  logic [2:0] Iter;

  modport master (
    output Run, ClearA_LoadB, M,
    input  ClearA, LoadB, LoadA, Fn, Shift, Busy, Done, Iter
  );

  modport slave (
    input  Run, ClearA_LoadB, M,
    output ClearA, LoadB, LoadA, Fn, Shift, Busy, Done, Iter
  );
endinterface

// File: rtl/mult_seq.sv
// Sequencer for an 8-bit signed shift-add multiplier (X:A:B chain).
// Optional macro MULT_SEQ_ACCUM_EN: CLR leaves A:X intact so runs accumulate.
module mult_seq (
  input  logic       Clk,
  input  logic       Reset_n,
  mult_seq_if.slave  bus
);

  localparam int unsigned ITER_W   = 3;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(7);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              run_q;
  logic              start_c;

  logic clear_a, load_b, load_a, fn, shift, busy, done;

  // Rising edge of Run; run_q resets high so a held Run cannot start after reset.
  assign start_c = bus.Run & ~run_q;

  // State, iteration counter and Run history.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      run_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      run_q   <= bus.Run;
    end
  end

  // Next state and control decode; only LoadA looks at M.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    clear_a = 1'b0;
    load_b  = 1'b0;
    load_a  = 1'b0;
    fn      = 1'b0;
    shift   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d = S_CLR;
        end else if (bus.ClearA_LoadB) begin
          clear_a = 1'b1;
          load_b  = 1'b1;
        end
      end
      S_CLR: begin
        busy    = 1'b1;
`ifdef MULT_SEQ_ACCUM_EN
        clear_a = 1'b0;
`else
        clear_a = 1'b1;
`endif
        iter_d  = '0;
        state_d = S_ADD;
      end
      S_ADD: begin
        busy    = 1'b1;
        load_a  = bus.M;
        fn      = (iter_q == ITER_LAST);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (iter_q == ITER_LAST) begin
          state_d = S_DONE;
        end else begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (!bus.Run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ClearA = clear_a;
  assign bus.LoadB  = load_b;
  assign bus.LoadA  = load_a;
  assign bus.Fn     = fn;
  assign bus.Shift  = shift;
  assign bus.Busy   = busy;
  assign bus.Done   = done;
  // Counter is only exposed once the sequence has cleared it.
  assign bus.Iter   = (state_q == S_ADD || state_q == S_SHIFT || state_q == S_DONE) ? iter_q : '0;

endmodule
